// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, functs,
// FSM states, ALU codes, datapath select values and the control output bundle.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;

    localparam logic [1:0] REG_DST_RT    = 2'b00;
    localparam logic [1:0] REG_DST_RD    = 2'b01;
    localparam logic [1:0] REG_DST_RA    = 2'b10;

    localparam logic [1:0] M2R_ALUOUT    = 2'b00;
    localparam logic [1:0] M2R_MDR       = 2'b01;
    localparam logic [1:0] M2R_PC        = 2'b10;

    localparam logic [1:0] ALUB_REGB     = 2'b00;
    localparam logic [1:0] ALUB_FOUR     = 2'b01;
    localparam logic [1:0] ALUB_IMM      = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2  = 2'b11;

    localparam logic [1:0] PCSRC_ALU     = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
    localparam logic [1:0] PCSRC_JADDR   = 2'b10;
    localparam logic [1:0] PCSRC_REGA    = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_WB_R     = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_HALT     = 4'd14
    } state_e;

    typedef struct packed {
        logic lw;
        logic sw;
        logic add;
        logic sub;
        logic slt;
        logic jr;
        logic addi;
        logic xori;
        logic beq;
        logic bne;
        logic j;
        logic jal;
    } instr_class_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       pc_write_u;
        logic       alu_src_a;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_ctrl;
    } ctrl_out_t;

endpackage

// File: rtl/ctrl_instr_class.sv
// Combinational instruction classifier: opcode/funct to a one-hot class,
// with illegal raised when no supported instruction matches.
module ctrl_instr_class
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic         illegal
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  cls.add = 1'b1;
                    FN_SUB:  cls.sub = 1'b1;
                    FN_SLT:  cls.slt = 1'b1;
                    FN_JR:   cls.jr  = 1'b1;
                    default: ;
                endcase
            end
            OP_LW:   cls.lw   = 1'b1;
            OP_SW:   cls.sw   = 1'b1;
            OP_ADDI: cls.addi = 1'b1;
            OP_XORI: cls.xori = 1'b1;
            OP_BEQ:  cls.beq  = 1'b1;
            OP_BNE:  cls.bne  = 1'b1;
            OP_J:    cls.j    = 1'b1;
            OP_JAL:  cls.jal  = 1'b1;
            default: ;
        endcase
        illegal = (cls == '0);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS-subset CPU. Optional illegal-
// instruction trap (HALT + sticky illegal_op) under MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 when memory ready
// DECODE   | dispatch, precompute branch target into ALUOut
// MEM_ADDR | effective address = regA + sext(imm)
// MEM_RD   | load access, wait for memory
// MEM_WB   | write MDR to rt
// MEM_WR   | store access, wait for memory
// EXEC_R   | R-type ALU op
// EXEC_I   | immediate ALU op
// WB_R     | write ALUOut to rd
// WB_I     | write ALUOut to rt
// BRANCH   | compare, conditional PC load from ALUOut
// JUMP     | PC = jump address
// JAL      | $31 = PC+4 and PC = jump address on the same edge
// JR       | PC = regA
// HALT     | stopped; left only through reset
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       mem_timeout,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    output logic       illegal_op,
`endif
    output logic [3:0] state_out
);

    localparam int unsigned CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    state_e       state_q, state_d;
    ctrl_out_t    out_q, out_d;
    logic [CW-1:0] stall_q, stall_d;
    logic         timeout_q, timeout_d;
    logic         stall;
    instr_class_t cls;
    logic         illegal;
    logic         in_fetch;
    logic         branch_taken;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic         illegal_q, illegal_d;
`endif

    ctrl_instr_class u_class (
        .opcode  (opcode),
        .funct   (funct),
        .cls     (cls),
        .illegal (illegal)
    );

    function automatic ctrl_out_t moore_out(input state_e s, input instr_class_t c);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.mem_read  = 1'b1;
                o.alu_src_b = ALUB_FOUR;
                o.alu_ctrl  = ALU_ADD;
                o.pc_src    = PCSRC_ALU;
            end
            S_DECODE:   o.alu_src_b = ALUB_IMM_SH2;
            S_MEM_ADDR: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = ALUB_IMM;
            end
            S_MEM_RD: begin
                o.mem_read = 1'b1;
                o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o.reg_write  = 1'b1;
                o.reg_dst    = REG_DST_RT;
                o.mem_to_reg = M2R_MDR;
            end
            S_MEM_WR: begin
                o.mem_write = 1'b1;
                o.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = ALUB_REGB;
                o.alu_ctrl  = c.sub ? ALU_SUB : (c.slt ? ALU_SLT : ALU_ADD);
            end
            S_WB_R: begin
                o.reg_write  = 1'b1;
                o.reg_dst    = REG_DST_RD;
                o.mem_to_reg = M2R_ALUOUT;
            end
            S_EXEC_I: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = ALUB_IMM;
                o.alu_ctrl  = c.xori ? ALU_XOR : ALU_ADD;
            end
            S_WB_I:     o.reg_write = 1'b1;
            S_BRANCH: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = ALUB_REGB;
                o.alu_ctrl  = ALU_SUB;
                o.pc_src    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o.pc_write_u = 1'b1;
                o.pc_src     = PCSRC_JADDR;
            end
            S_JAL: begin
                o.reg_write  = 1'b1;
                o.reg_dst    = REG_DST_RA;
                o.mem_to_reg = M2R_PC;
                o.pc_write_u = 1'b1;
                o.pc_src     = PCSRC_JADDR;
            end
            S_JR: begin
                o.pc_write_u = 1'b1;
                o.pc_src     = PCSRC_REGA;
            end
            default: ;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d   = state_q;
        stall_d   = '0;
        timeout_d = timeout_q;
        stall     = 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           stall   = 1'b1;
            end
            S_DECODE: begin
                if (illegal) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
`else
                    state_d   = S_FETCH;
`endif
                end
                else if (cls.lw || cls.sw)               state_d = S_MEM_ADDR;
                else if (cls.jr)                         state_d = S_JR;
                else if (cls.add || cls.sub || cls.slt)  state_d = S_EXEC_R;
                else if (cls.addi || cls.xori)           state_d = S_EXEC_I;
                else if (cls.beq || cls.bne)             state_d = S_BRANCH;
                else if (cls.j)                          state_d = S_JUMP;
                else                                     state_d = S_JAL;
            end
            S_MEM_ADDR: state_d = cls.sw ? S_MEM_WR : (cls.lw ? S_MEM_RD : S_FETCH);
            S_MEM_RD: begin
                if (mem_ready) state_d = S_MEM_WB;
                else           stall   = 1'b1;
            end
            S_MEM_WR: begin
                if (mem_ready) state_d = S_FETCH;
                else           stall   = 1'b1;
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            S_MEM_WB, S_WB_R, S_WB_I, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase

        // MEM_WAIT_MAX stall cycles are tolerated; one more trips the timeout.
        if (stall && (MEM_WAIT_MAX != 0)) begin
            if (stall_q == CW'(MEM_WAIT_MAX)) begin
                state_d   = S_HALT;
                timeout_d = 1'b1;
            end else begin
                stall_d = stall_q + CW'(1);
            end
        end

        out_d = moore_out(state_d, cls);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            out_q     <= moore_out(S_FETCH, instr_class_t'('0));
            stall_q   <= '0;
            timeout_q <= 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Reset masks everything so no strobe fires on the reset edge itself.
    assign in_fetch     = (state_q == S_FETCH);
    assign branch_taken = (state_q == S_BRANCH) && (zero ^ cls.bne);

    assign pc_write    = !reset && (out_q.pc_write_u || (in_fetch && mem_ready) || branch_taken);
    assign ir_write    = !reset && in_fetch && mem_ready;
    assign i_or_d      = !reset && out_q.i_or_d;
    assign mem_read    = !reset && out_q.mem_read;
    assign mem_write   = !reset && out_q.mem_write;
    assign reg_write   = !reset && out_q.reg_write;
    assign reg_dst     = reset ? 2'b00 : out_q.reg_dst;
    assign mem_to_reg  = reset ? 2'b00 : out_q.mem_to_reg;
    assign alu_src_a   = !reset && out_q.alu_src_a;
    assign alu_src_b   = reset ? 2'b00 : out_q.alu_src_b;
    assign alu_ctrl    = reset ? 3'b000 : out_q.alu_ctrl;
    assign pc_src      = reset ? 2'b00 : out_q.pc_src;
    assign mem_timeout = !reset && timeout_q;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    assign illegal_op  = !reset && illegal_q;
`endif
    assign state_out   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle vector table, timeout/reset sequences,
// and random instruction streams checked against an instruction-level model.
module tb_multicycle_ctrl;

    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1, ST_MADDR = 4'd2,
                           ST_MRD   = 4'd3,  ST_MWB    = 4'd4, ST_MWR   = 4'd5,
                           ST_EXR   = 4'd6,  ST_EXI    = 4'd7, ST_WBR   = 4'd8,
                           ST_WBI   = 4'd9,  ST_BR     = 4'd10, ST_J    = 4'd11,
                           ST_JAL   = 4'd12, ST_JR     = 4'd13, ST_HALT = 4'd14;

    // {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
    //  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src}
    localparam logic [17:0] E_ZERO      = 18'b0;
    localparam logic [17:0] E_FETCH_RDY = 18'b1_1_0_1_0_0_00_00_0_01_000_00;
    localparam logic [17:0] E_FETCH_WT  = 18'b0_0_0_1_0_0_00_00_0_01_000_00;
    localparam logic [17:0] E_DECODE    = 18'b0_0_0_0_0_0_00_00_0_11_000_00;
    localparam logic [17:0] E_EXR_ADD   = 18'b0_0_0_0_0_0_00_00_1_00_000_00;
    localparam logic [17:0] E_EXR_SLT   = 18'b0_0_0_0_0_0_00_00_1_00_011_00;
    localparam logic [17:0] E_WBR       = 18'b0_0_0_0_0_1_01_00_0_00_000_00;
    localparam logic [17:0] E_MADDR     = 18'b0_0_0_0_0_0_00_00_1_10_000_00;
    localparam logic [17:0] E_MRD       = 18'b0_0_1_1_0_0_00_00_0_00_000_00;
    localparam logic [17:0] E_MWB       = 18'b0_0_0_0_0_1_00_01_0_00_000_00;
    localparam logic [17:0] E_MWR       = 18'b0_0_1_0_1_0_00_00_0_00_000_00;
    localparam logic [17:0] E_BR_T      = 18'b1_0_0_0_0_0_00_00_1_00_001_01;
    localparam logic [17:0] E_BR_NT     = 18'b0_0_0_0_0_0_00_00_1_00_001_01;
    localparam logic [17:0] E_JAL       = 18'b1_0_0_0_0_1_10_10_0_00_000_10;
    localparam logic [17:0] E_EXI_XOR   = 18'b0_0_0_0_0_0_00_00_1_10_010_00;
    localparam logic [17:0] E_WBI       = 18'b0_0_0_0_0_1_00_00_0_00_000_00;
    localparam logic [17:0] E_JR        = 18'b1_0_0_0_0_0_00_00_0_00_000_11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b1;

    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a, mem_timeout;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state_out;

    logic       pc_write_n, ir_write_n, i_or_d_n, mem_read_n, mem_write_n, reg_write_n, alu_src_a_n, mem_timeout_n;
    logic [1:0] reg_dst_n, mem_to_reg_n, alu_src_b_n, pc_src_n;
    logic [2:0] alu_ctrl_n;
    logic [3:0] state_out_n;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op, illegal_op_n;
`endif

    logic [17:0] outs;
    assign outs = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src};

    multicycle_ctrl #(.MEM_WAIT_MAX(3)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
        .mem_timeout(mem_timeout),
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .state_out(state_out)
    );

    multicycle_ctrl u_inf (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write_n), .ir_write(ir_write_n), .i_or_d(i_or_d_n), .mem_read(mem_read_n),
        .mem_write(mem_write_n), .reg_write(reg_write_n), .reg_dst(reg_dst_n), .mem_to_reg(mem_to_reg_n),
        .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n), .alu_ctrl(alu_ctrl_n), .pc_src(pc_src_n),
        .mem_timeout(mem_timeout_n),
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op_n),
`endif
        .state_out(state_out_n)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic rdy);
        @(negedge clk);
        reset = r; opcode = op; funct = fn; zero = z; mem_ready = rdy;
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void vec(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic rdy, input logic [3:0] st,
                                input logic [17:0] e);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.exp = e;
        vecs.push_back(v);
    endfunction

    // Instruction list for the random stream: LW SW J JAL JR BEQ BNE ADDI XORI ADD SUB SLT
    logic [5:0] r_op[12] = '{6'h23, 6'h2B, 6'h02, 6'h03, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0E, 6'h00, 6'h00, 6'h00};
    logic [5:0] r_fn[12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h22, 6'h2A};

    initial begin
        // ---------------- per-cycle vector table ----------------
        vec(1, 6'h00, 6'h20, 0, 1, ST_FETCH, E_ZERO);
        vec(0, 6'h00, 6'h20, 0, 1, ST_FETCH, E_FETCH_RDY);       // ADD
        vec(0, 6'h00, 6'h20, 0, 1, ST_DECODE, E_DECODE);
        vec(0, 6'h00, 6'h20, 0, 1, ST_EXR, E_EXR_ADD);
        vec(0, 6'h00, 6'h20, 0, 1, ST_WBR, E_WBR);
        vec(0, 6'h23, 6'h00, 0, 1, ST_FETCH, E_FETCH_RDY);       // LW, two memory stalls
        vec(0, 6'h23, 6'h00, 0, 1, ST_DECODE, E_DECODE);
        vec(0, 6'h23, 6'h00, 0, 1, ST_MADDR, E_MADDR);
        vec(0, 6'h23, 6'h00, 0, 0, ST_MRD, E_MRD);
        vec(0, 6'h23, 6'h00, 0, 0, ST_MRD, E_MRD);
        vec(0, 6'h23, 6'h00, 0, 1, ST_MRD, E_MRD);
        vec(0, 6'h23, 6'h00, 0, 1, ST_MWB, E_MWB);
        vec(0, 6'h04, 6'h00, 1, 1, ST_FETCH, E_FETCH_RDY);       // BEQ taken
        vec(0, 6'h04, 6'h00, 1, 1, ST_DECODE, E_DECODE);
        vec(0, 6'h04, 6'h00, 1, 1, ST_BR, E_BR_T);
        vec(0, 6'h05, 6'h00, 1, 1, ST_FETCH, E_FETCH_RDY);       // BNE not taken
        vec(0, 6'h05, 6'h00, 1, 1, ST_DECODE, E_DECODE);
        vec(0, 6'h05, 6'h00, 1, 1, ST_BR, E_BR_NT);
        vec(0, 6'h03, 6'h00, 0, 1, ST_FETCH, E_FETCH_RDY);       // JAL
        vec(0, 6'h03, 6'h00, 0, 1, ST_DECODE, E_DECODE);
        vec(0, 6'h03, 6'h00, 0, 1, ST_JAL, E_JAL);
        vec(0, 6'h03, 6'h00, 0, 0, ST_FETCH, E_FETCH_WT);
        vec(0, 6'h2B, 6'h00, 0, 1, ST_FETCH, E_FETCH_RDY);       // SW, reset mid-stall
        vec(0, 6'h2B, 6'h00, 0, 1, ST_DECODE, E_DECODE);
        vec(0, 6'h2B, 6'h00, 0, 1, ST_MADDR, E_MADDR);
        vec(0, 6'h2B, 6'h00, 0, 0, ST_MWR, E_MWR);
        vec(1, 6'h2B, 6'h00, 0, 0, ST_MWR, E_ZERO);
        vec(0, 6'h2B, 6'h00, 0, 0, ST_FETCH, E_FETCH_WT);
        vec(0, 6'h00, 6'h2A, 0, 1, ST_FETCH, E_FETCH_RDY);       // SLT
        vec(0, 6'h00, 6'h2A, 0, 1, ST_DECODE, E_DECODE);
        vec(0, 6'h00, 6'h2A, 0, 1, ST_EXR, E_EXR_SLT);
        vec(0, 6'h00, 6'h2A, 0, 1, ST_WBR, E_WBR);
        vec(0, 6'h0E, 6'h00, 0, 1, ST_FETCH, E_FETCH_RDY);       // XORI
        vec(0, 6'h0E, 6'h00, 0, 1, ST_DECODE, E_DECODE);
        vec(0, 6'h0E, 6'h00, 0, 1, ST_EXI, E_EXI_XOR);
        vec(0, 6'h0E, 6'h00, 0, 1, ST_WBI, E_WBI);
        vec(0, 6'h00, 6'h08, 0, 1, ST_FETCH, E_FETCH_RDY);       // JR
        vec(0, 6'h00, 6'h08, 0, 1, ST_DECODE, E_DECODE);
        vec(0, 6'h00, 6'h08, 0, 1, ST_JR, E_JR);
        vec(0, 6'h3F, 6'h00, 0, 1, ST_FETCH, E_FETCH_RDY);       // illegal opcode
        vec(0, 6'h3F, 6'h00, 0, 1, ST_DECODE, E_DECODE);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        vec(0, 6'h3F, 6'h00, 0, 0, ST_HALT, E_ZERO);
`else
        vec(0, 6'h3F, 6'h00, 0, 0, ST_FETCH, E_FETCH_WT);
`endif

        @(posedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
            check($sformatf("vec%0d state", i), 32'(state_out), 32'(vecs[i].st));
            check($sformatf("vec%0d outputs", i), 32'(outs), 32'(vecs[i].exp));
        end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        check("illegal_op set", 32'(illegal_op), 32'd1);
`endif

        // ---------------- timeout and reset-from-HALT ----------------
        drive(1, 6'h00, 6'h20, 0, 0);
        drive(1, 6'h00, 6'h20, 0, 0);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        check("illegal_op cleared", 32'(illegal_op), 32'd0);
`endif
        for (int k = 0; k < 20; k++) begin
            drive(0, 6'h00, 6'h20, 0, 0);
            if (k == 3) begin
                check("last tolerated stall state", 32'(state_out), 32'(ST_FETCH));
                check("last tolerated stall timeout", 32'(mem_timeout), 32'd0);
            end
            if (k == 4) begin
                check("timeout state", 32'(state_out), 32'(ST_HALT));
                check("timeout flag", 32'(mem_timeout), 32'd1);
                check("halt outputs", 32'(outs), 32'd0);
            end
        end
        check("unlimited wait state", 32'(state_out_n), 32'(ST_FETCH));
        check("unlimited wait timeout", 32'(mem_timeout_n), 32'd0);
        for (int k = 0; k < 3; k++) drive(0, 6'h00, 6'h20, 0, 1);
        check("halt is sticky", 32'(state_out), 32'(ST_HALT));
        check("timeout sticky", 32'(mem_timeout), 32'd1);
        drive(1, 6'h00, 6'h20, 0, 1);
        check("timeout masked in reset", 32'(mem_timeout), 32'd0);

        // ---------------- random stream vs instruction-level model ----------------
        for (int i = 0; i < 80; i++) begin
            int k, sf, sm, ncyc, base;
            int irw, pcw, rw, mrd, mwr;
            int exp_pcw, exp_rw, exp_mrd, exp_mwr;
            logic z, is_mem, taken, rdy;
            logic [3:0] sel_seen, exp_sel;
            logic [1:0] pcs_seen, exp_pcs;
            k  = $urandom_range(0, 11);
            sf = $urandom_range(0, 3);
            sm = $urandom_range(0, 3);
            z  = 1'($urandom_range(0, 1));
            is_mem = (k <= 1);
            base   = (k == 0) ? 5 : ((k == 1 || k >= 7) ? 4 : 3);
            ncyc   = base + sf + (is_mem ? sm : 0);
            taken  = (k == 5 && z) || (k == 6 && !z);
            exp_pcw = 1 + ((k >= 2 && k <= 4) ? 1 : 0) + (taken ? 1 : 0);
            exp_rw  = (k == 0 || k == 3 || k >= 7) ? 1 : 0;
            exp_mrd = sf + 1 + ((k == 0) ? sm + 1 : 0);
            exp_mwr = (k == 1) ? sm + 1 : 0;
            exp_sel = (k == 0) ? 4'b00_01 : (k == 3) ? 4'b10_10 : (k >= 9) ? 4'b01_00 : 4'b00_00;
            exp_pcs = (k == 4) ? 2'b11 : ((k == 2 || k == 3) ? 2'b10 : 2'b01);
            irw = 0; pcw = 0; rw = 0; mrd = 0; mwr = 0;
            sel_seen = 4'hF; pcs_seen = 2'b00;
            for (int c = 0; c < ncyc; c++) begin
                rdy = !((c < sf) || (is_mem && c >= sf + 3 && c < sf + 3 + sm));
                drive(0, r_op[k], r_fn[k], z, rdy);
                if (c == 0) check($sformatf("rnd%0d start state", i), 32'(state_out), 32'(ST_FETCH));
                irw += int'(ir_write);
                pcw += int'(pc_write);
                rw  += int'(reg_write);
                mrd += int'(mem_read);
                mwr += int'(mem_write);
                if (reg_write) sel_seen = {reg_dst, mem_to_reg};
                if (pc_write && !ir_write) pcs_seen = pc_src;
            end
            check($sformatf("rnd%0d ir_write count", i), 32'(irw), 32'd1);
            check($sformatf("rnd%0d pc_write count", i), 32'(pcw), 32'(exp_pcw));
            check($sformatf("rnd%0d reg_write count", i), 32'(rw), 32'(exp_rw));
            check($sformatf("rnd%0d mem_read cycles", i), 32'(mrd), 32'(exp_mrd));
            check($sformatf("rnd%0d mem_write cycles", i), 32'(mwr), 32'(exp_mwr));
            if (exp_rw == 1) check($sformatf("rnd%0d writeback selects", i), 32'(sel_seen), 32'(exp_sel));
            if (exp_pcw > 1) check($sformatf("rnd%0d pc_src", i), 32'(pcs_seen), 32'(exp_pcs));
        end
        @(negedge clk);
        #1;
        check("final state", 32'(state_out), 32'(ST_FETCH));
        check("no spurious timeout", 32'(mem_timeout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS-subset CPU.
- Consumes the opcode/funct fields split out of the instruction register, plus the ALU zero flag and a memory ready flag.
- Sequences fetch, decode, execute, memory and writeback steps by driving every datapath mux select and write enable.
- Supported instructions: LW, SW, J, JAL, JR, BEQ, BNE, ADDI, XORI, ADD, SUB, SLT.

Parameters:
- MEM_WAIT_MAX, default 0: maximum number of consecutive stall cycles per memory access. 0 means unlimited.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26], from IR
- funct  in  6  instruction[5:0], from IR
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable (includes the resolved branch condition)
- ir_write  out  1  IR load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- reg_write  out  1  register file write enable
- reg_dst  out  2  destination select: 00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  writeback data select: 00 = ALUOut, 01 = MDR, 10 = PC
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = regA
- alu_src_b  out  2  ALU B select: 00 = regB, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2
- alu_ctrl  out  3  ALU op: 000 = ADD, 001 = SUB, 010 = XOR, 011 = SLT
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], addr, 00}, 11 = regA
- mem_timeout  out  1  sticky; asserted when MEM_WAIT_MAX is exceeded
- state_out  out  4  current state encoding, for debug

Behaviour:
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, WB_R, WB_I, BRANCH, JUMP, JAL, JR, HALT.
- Moore outputs decoded from state, with two exceptions:
  - ir_write/pc_write in FETCH are qualified by mem_ready.
  - pc_write in BRANCH = zero XOR (opcode==BNE).
- Reset:
  - While reset is high, all enables/strobes are 0, all selects are 0, and mem_timeout is 0.
  - Next state is FETCH.
  - Reset in any state (including mid-stall or HALT) returns to FETCH on the next edge; no write strobes are issued on that edge.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, ADD (precomputes branch target into ALUOut).
  - Dispatch by opcode:
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x00 with funct 0x08 -> JR
    - 0x00 with funct 0x20, 0x22 or 0x2A -> EXEC_R
    - 0x08 or 0x0E -> EXEC_I
    - 0x04 or 0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x03 -> JAL
    - anything else -> illegal handling (see Optional Feature)
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, ADD.
  - Next: MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- EXEC_R:
  - Outputs: alu_src_a=1, alu_src_b=00.
  - alu_ctrl from funct: 0x20 = ADD, 0x22 = SUB, 0x2A = SLT.
  - Next: WB_R.
- WB_R: reg_write=1, reg_dst=01, mem_to_reg=00, then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, ADD for 0x08 / XOR for 0x0E, then WB_I.
  - XORI uses sign extension here too, so the datapath zero-extends for XORI.
- WB_I: reg_write=1, reg_dst=00, mem_to_reg=00, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, then FETCH.
- JUMP: pc_write=1, pc_src=10, then FETCH.
- JAL:
  - Outputs: reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_src=10.
  - Link value is the PC already incremented to PC+4; the register write and PC update occur on the same edge.
  - Next: FETCH.
- JR: pc_write=1, pc_src=11, then FETCH.
- Latency with mem_ready=1 every cycle:
  - BEQ/BNE, J, JAL, JR: 3 cycles.
  - R-type, I-type ALU, SW: 4 cycles.
  - LW: 5 cycles.
  - Each stall cycle adds 1.
- Stall counter:
  - Counts consecutive cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0; cleared on state change.
  - If MEM_WAIT_MAX>0 and the counter reaches MEM_WAIT_MAX: set mem_timeout, go to HALT.
- HALT: all enables 0. Exit only via reset.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode/funct in DECODE goes to HALT and sets the sticky output illegal_op (extra 1-bit port, cleared only by reset).
- Undefined: an illegal instruction is a NOP (DECODE -> FETCH, no writes), and the illegal_op port is absent.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - Opcode/funct localparams: OP_RTYPE, OP_LW, OP_SW, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, FN_ADD, FN_SUB, FN_SLT, FN_JR.
  - State enum.
  - ALU_ADD/SUB/XOR/SLT codes.
  - Select encodings for reg_dst, mem_to_reg, alu_src_b, pc_src.
- One sub-module, ctrl_instr_class: combinational opcode/funct to one-hot instruction class plus illegal flag. The FSM uses it for dispatch and alu_ctrl.

Test Plan:
- ADD (opcode 0x00, funct 0x20), mem_ready=1 -> state sequence FETCH, DECODE, EXEC_R, WB_R. WB_R shows reg_write=1, reg_dst=01, mem_to_reg=00. 4 cycles total.
- LW (0x23) with mem_ready low for 2 cycles in MEM_RD -> mem_read=1 and i_or_d=1 held 3 cycles. reg_write pulses once in MEM_WB. 7 cycles total.
- BEQ (0x04) with zero=1 -> pc_write=1 and pc_src=01 in BRANCH. BNE (0x05) with zero=1 -> pc_write=0.
- JAL (0x03) -> one-cycle pulse with reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_src=10. Back in FETCH on the next cycle.
- Reset asserted during a MEM_WR stall -> mem_write=0 on the reset edge, state_out=FETCH on the next cycle. With MEM_WAIT_MAX=3 and mem_ready held 0 in FETCH -> mem_timeout=1, HALT.
- Opcode 0x3F -> HALT with illegal_op=1 when MULTICYCLE_CTRL_ILLEGAL_TRAP_EN is defined; otherwise DECODE -> FETCH with no write strobes.
